seq_detector_param: RTL and testbench

Programmable sequence detector for a stream of SYM_W-bit symbols. It matches a runtime-loaded pattern of 1..MAX_LEN symbols. It supports overlapping and non-overlapping modes, emits a one-cycle match pulse, and keeps a saturating hit counter. It sits on the symbol-stream side of the datapath and is the generalised replacement for the fixed-pattern 2-bit detectors.

---
 rtl/seq_detector_param.sv | 127 ++++++++++++
 tb/tb_seq_detector_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Programmable symbol-sequence detector: runtime pattern of 1..MAX_LEN
// symbols, overlap control, registered match pulse and saturating hit count.
module seq_detector_param #(
   parameter int SYM_W   = 2,
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   localparam int AW     = $clog2(MAX_LEN),
   localparam int LW     = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [SYM_W-1:0] in_sym,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [SYM_W-1:0] cfg_sym,
   input  logic             len_we,
   input  logic [LW-1:0]    cfg_len,
   input  logic             overlap,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [LW-1:0]    fill
);

   localparam logic [LW-1:0]    FILL_MAX = LW'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [MAX_LEN-1:0][SYM_W-1:0] pat_q, pat_d;
   logic [MAX_LEN-1:0][SYM_W-1:0] hist_q, hist_d;
   logic [LW-1:0]                 len_q, len_d;
   logic [LW-1:0]                 fill_q, fill_d;
   logic                          match_q, match_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;

   logic          cfg_wr;
   logic          shift;
   logic          len_ok;
   logic          pat_eq;
   logic          hit;
   logic [AW-1:0] pidx;

   assign cfg_wr = cfg_we | len_we;
   assign shift  = in_valid & ~cfg_wr;
   assign len_ok = (len_q != '0) && (len_q <= FILL_MAX);

   // Pattern and length registers
   always_comb begin
      pat_d = pat_q;
      len_d = len_q;
      if (cfg_we && ({1'b0, cfg_addr} < (AW + 1)'(MAX_LEN))) begin
         pat_d[cfg_addr] = cfg_sym;
      end
      if (len_we) begin
         len_d = cfg_len;
      end
   end

   // History shift; slot 0 is the newest symbol
   always_comb begin
      hist_d = hist_q;
      if (shift) begin
         hist_d[0] = in_sym;
         for (int k = 1; k < MAX_LEN; k++) begin
            hist_d[k] = hist_q[k-1];
         end
      end
   end

   // Newest history slot k lines up with pattern slot len-1-k
   always_comb begin
      pat_eq = 1'b1;
      pidx   = '0;
      for (int k = 0; k < MAX_LEN; k++) begin
         pidx = AW'(len_q - LW'(k) - LW'(1));
         if (LW'(k) < len_q) begin
            if (hist_d[k] != pat_q[pidx]) begin
               pat_eq = 1'b0;
            end
         end
      end
   end

   always_comb begin
      fill_d = fill_q;
      if (shift && (fill_q != FILL_MAX)) begin
         fill_d = fill_q + LW'(1);
      end
      hit = shift & len_ok & (fill_d >= len_q) & pat_eq;
      if ((hit && !overlap) || cfg_wr) begin
         fill_d = '0;
      end
   end

   always_comb begin
      match_d = hit;
      cnt_d   = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q   <= '0;
         len_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         len_q   <= len_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end

   assign match   = match_q;
   assign hit_cnt = cnt_q;
   assign fill    = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param, plus a narrow-counter
// instance for saturation and clear-priority sequences.
module tb_seq_detector_param;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [1:0] in_sym;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [1:0] cfg_sym;
   logic       len_we;
   logic [3:0] cfg_len;
   logic       overlap;
   logic       cnt_clr;
   logic       match;
   logic [7:0] hit_cnt;
   logic [3:0] fill;
   logic       match2;
   logic [1:0] hit_cnt2;
   logic [3:0] fill2;

   int n_cmp = 0;
   int n_bad = 0;

   seq_detector_param u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sym(in_sym),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sym(cfg_sym),
      .len_we(len_we), .cfg_len(cfg_len), .overlap(overlap),
      .cnt_clr(cnt_clr), .match(match), .hit_cnt(hit_cnt), .fill(fill)
   );

   seq_detector_param #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sym(in_sym),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sym(cfg_sym),
      .len_we(len_we), .cfg_len(cfg_len), .overlap(overlap),
      .cnt_clr(cnt_clr), .match(match2), .hit_cnt(hit_cnt2), .fill(fill2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       vld;
      logic [1:0] sym;
      logic       cwe;
      logic [2:0] addr;
      logic [1:0] csym;
      logic       lwe;
      logic [3:0] len;
      logic       ovl;
      logic       clr;
      logic       em;
      logic [7:0] ec;
      logic [3:0] ef;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(
      input logic r, vl, input logic [1:0] s,
      input logic cw, input logic [2:0] a, input logic [1:0] cs,
      input logic lw, input logic [3:0] l, input logic o, cl,
      input logic em, input logic [7:0] ec, input logic [3:0] ef);
      vec_t t;
      t.rst = r;  t.vld = vl;  t.sym = s;
      t.cwe = cw; t.addr = a;  t.csym = cs;
      t.lwe = lw; t.len = l;   t.ovl = o;  t.clr = cl;
      t.em = em;  t.ec = ec;   t.ef = ef;
      return t;
   endfunction

   // valid symbol row
   function automatic vec_t vs(input logic [1:0] s, input logic o,
      input logic em, input logic [7:0] ec, input logic [3:0] ef);
      return v(0, 1, s, 0, 0, 0, 0, 0, o, 0, em, ec, ef);
   endfunction

   // config row: slot write, optional length write, optional clear
   function automatic vec_t vc(input logic [2:0] a, input logic [1:0] cs,
      input logic lw, input logic [3:0] l, input logic cl,
      input logic [7:0] ec);
      return v(0, 0, 0, 1, a, cs, lw, l, 1, cl, 0, ec, 0);
   endfunction

   // idle row
   function automatic vec_t vi(input logic [7:0] ec, input logic [3:0] ef);
      return v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ec, ef);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      reset    = t.rst;
      in_valid = t.vld;
      in_sym   = t.sym;
      cfg_we   = t.cwe;
      cfg_addr = t.addr;
      cfg_sym  = t.csym;
      len_we   = t.lwe;
      cfg_len  = t.len;
      overlap  = t.ovl;
      cnt_clr  = t.clr;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(vi(0, 0));

      // basic 01,10,11 match
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(vc(0, 1, 0, 0, 0, 0));
      tbl.push_back(vc(1, 2, 0, 0, 0, 0));
      tbl.push_back(vc(2, 3, 1, 3, 0, 0));
      tbl.push_back(vs(1, 1, 0, 0, 1));
      tbl.push_back(vs(2, 1, 0, 0, 2));
      tbl.push_back(vs(3, 1, 1, 1, 3));
      tbl.push_back(vi(1, 3));
      // gaps are transparent
      tbl.push_back(vs(1, 1, 0, 1, 4));
      tbl.push_back(vi(1, 4));
      tbl.push_back(vi(1, 4));
      tbl.push_back(vi(1, 4));
      tbl.push_back(vs(2, 1, 0, 1, 5));
      tbl.push_back(vs(3, 1, 1, 2, 6));
      tbl.push_back(vi(2, 6));
      // 01,10,10,11 must not match
      tbl.push_back(vs(1, 1, 0, 2, 7));
      tbl.push_back(vs(2, 1, 0, 2, 8));
      tbl.push_back(vs(2, 1, 0, 2, 8));
      tbl.push_back(vs(3, 1, 0, 2, 8));
      // 01,01 overlapping
      tbl.push_back(vc(1, 1, 1, 2, 1, 0));
      tbl.push_back(vs(1, 1, 0, 0, 1));
      tbl.push_back(vs(1, 1, 1, 1, 2));
      tbl.push_back(vs(1, 1, 1, 2, 3));
      tbl.push_back(vs(1, 1, 1, 3, 4));
      // 01,01 non-overlapping
      tbl.push_back(vc(0, 1, 1, 2, 1, 0));
      tbl.push_back(vs(1, 0, 0, 0, 1));
      tbl.push_back(vs(1, 0, 1, 1, 0));
      tbl.push_back(vs(1, 0, 0, 1, 1));
      tbl.push_back(vs(1, 0, 1, 2, 0));
      tbl.push_back(vi(2, 0));
      // config write drops a coincident symbol
      tbl.push_back(vc(1, 2, 0, 0, 1, 0));
      tbl.push_back(vc(2, 3, 1, 3, 0, 0));
      tbl.push_back(vs(1, 1, 0, 0, 1));
      tbl.push_back(vs(2, 1, 0, 0, 2));
      tbl.push_back(v(0, 1, 3, 1, 2, 3, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(vi(0, 0));
      tbl.push_back(vs(3, 1, 0, 0, 1));
      // len 0 disabled
      tbl.push_back(vc(0, 1, 1, 0, 0, 0));
      tbl.push_back(vs(1, 1, 0, 0, 1));
      tbl.push_back(vs(2, 1, 0, 0, 2));
      tbl.push_back(vs(3, 1, 0, 0, 3));
      // len 9 disabled
      tbl.push_back(vc(0, 1, 1, 9, 0, 0));
      tbl.push_back(vs(1, 1, 0, 0, 1));
      tbl.push_back(vs(2, 1, 0, 0, 2));
      tbl.push_back(vs(3, 1, 0, 0, 3));
      // len 3 re-enabled, pattern intact
      tbl.push_back(vc(0, 1, 1, 3, 0, 0));
      tbl.push_back(vs(1, 1, 0, 0, 1));
      tbl.push_back(vs(2, 1, 0, 0, 2));
      tbl.push_back(vs(3, 1, 1, 1, 3));
      // reset mid-stream clears everything
      tbl.push_back(vs(1, 1, 0, 1, 4));
      tbl.push_back(vs(2, 1, 0, 1, 5));
      tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(vs(3, 1, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      tbl.push_back(vs(0, 1, 1, 1, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         cyc();
         chk($sformatf("row%0d match", i), match, tbl[i].em);
         chk($sformatf("row%0d hit_cnt", i), hit_cnt, tbl[i].ec);
         chk($sformatf("row%0d fill", i), fill, tbl[i].ef);
      end

      // narrow counter: saturation and clear priority
      drive(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      cyc();
      chk("cnt2 reset", hit_cnt2, 0);
      drive(vc(0, 3, 1, 1, 0, 0));
      cyc();
      chk("cnt2 cfg fill", fill2, 0);
      for (int i = 0; i < 5; i++) begin
         drive(vs(3, 1, 0, 0, 0));
         cyc();
         chk($sformatf("sat%0d match", i), match2, 1);
         chk($sformatf("sat%0d hit_cnt", i), hit_cnt2, (i < 3) ? i + 1 : 3);
      end
      drive(v(0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      cyc();
      chk("clr match", match2, 1);
      chk("clr hit_cnt", hit_cnt2, 0);
      drive(vi(0, 0));
      cyc();
      chk("post clr match", match2, 0);
      chk("post clr hit_cnt", hit_cnt2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
